// File: rtl/i_memory_pl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : nano_rv32i_pkg                                                   |
// | Purpose : Shared constants, fetch-FSM state type and address helper for    |
// |           the nano_rv32i instruction memory.                               |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial handshaked instruction memory                       |
// +----------------------------------------------------------------------------+
package nano_rv32i_pkg;

  // ADDI x0,x0,0: returned instead of array data on a faulting fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  // Byte address to word index; depth is a power of two, so the mask wraps
  // the index into the array (range faults are detected separately).
  function automatic logic [31:0] word_idx(input logic [31:0] addr,
                                           input int unsigned depth);
    return (addr >> 2) & (depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i_memory_pl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : i_memory_pl_if                                                 |
// | Purpose   : Fetch request/response handshake, flush, program-load port     |
// |             and error counter of the instruction memory.                   |
// | Modports  : master - fetch unit / loader side (drives *_i signals)         |
// |             slave  - memory side (drives *_o signals)                      |
// | Rev       : 1.0  initial handshaked instruction memory                     |
// +----------------------------------------------------------------------------+
interface i_memory_pl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_data_o;
  logic              rsp_err_o;
  logic              flush_i;
  logic              prog_we_i;
  logic [ADDR_W-1:0] prog_addr_i;
  logic [31:0]       prog_data_i;
  logic [7:0]        err_cnt_o;

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, flush_i,
           prog_we_i, prog_addr_i, prog_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, err_cnt_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, flush_i,
           prog_we_i, prog_addr_i, prog_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, err_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/i_memory_pl_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_array                                                       |
// | Purpose : DEPTH x 32 synchronous RAM, read-first, with a separate write    |
// |           port. Read data is registered on re and held otherwise.          |
// | Ports   : clk_i, rst_ni  clock / sync active-low reset (read reg only)     |
// |           re, raddr      read enable / word index                          |
// |           we, waddr,     write enable / word index / data                  |
// |           wdata                                                            |
// |           rdata          registered read data (NOP_WORD after reset)       |
// | Rev     : 1.0  initial handshaked instruction memory                       |
// +----------------------------------------------------------------------------+
module imem_array #(
  parameter int          DEPTH     = 256,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
  parameter int          IDX_W     = $clog2(DEPTH)
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             re,
  input  wire logic [IDX_W-1:0] raddr,
  input  wire logic             we,
  input  wire logic [IDX_W-1:0] waddr,
  input  wire logic [31:0]      wdata,
  output logic      [31:0]      rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Non-blocking read on the same edge as a write gives the old word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)  r_rdata <= NOP_WORD;
    else if (re)  r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/i_memory_pl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i_memory_pl                                                      |
// | Purpose : Handshaked instruction memory for the nano_rv32i fetch stage.    |
// |           Byte-addressed fetches, misaligned/out-of-range fault detection, |
// |           1..4 cycle read latency, flush, program-load port.               |
// | Ports   : clk_i   clock, rising edge                                       |
// |           rst_ni  synchronous reset, active-low                            |
// |           bus     i_memory_pl_if.slave (request, response, flush,          |
// |                   program port, err_cnt_o)                                 |
// | Rev     : 1.0  initial handshaked instruction memory                       |
// +----------------------------------------------------------------------------+
module i_memory_pl
  import nano_rv32i_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 1,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] NOP_WORD  = NOP_INSTR
) (
  input wire logic       clk_i,
  input wire logic       rst_ni,
  i_memory_pl_if.slave   bus
);

  localparam int         c_idx_w    = $clog2(DEPTH);
  localparam logic [1:0] c_cnt_load = 2'((LATENCY > 1) ? LATENCY - 2 : 0);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("i_memory_pl: LATENCY must be in 1..4");
  end
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 65536) begin : g_bad_depth
    $error("i_memory_pl: DEPTH must be a power of two in 4..65536");
  end

  imem_state_e          r_state, w_state_nxt;
  logic [1:0]           r_cnt, w_cnt_nxt;
  logic                 r_cap_fault;
  logic [31:0]          r_rsp_data;
  logic                 r_rsp_err;
  logic [7:0]           r_err_cnt;

  logic                 w_accept;
  logic                 w_fault;
  logic                 w_prog_ok;
  logic                 w_load_out;
  logic [c_idx_w-1:0]   w_ridx;
  logic [c_idx_w-1:0]   w_widx;
  logic [31:0]          w_arr_q;
  logic [31:0]          w_cap_data;

  // Fault: low two bits set, or any bit above the word-index field set.
  assign w_fault   = (|bus.req_addr_i[1:0]) ||
                     ((bus.req_addr_i >> (c_idx_w + 2)) != '0);
  assign w_prog_ok = !(|bus.prog_addr_i[1:0]) &&
                     ((bus.prog_addr_i >> (c_idx_w + 2)) == '0);
  assign w_ridx    = c_idx_w'(word_idx(32'(bus.req_addr_i), DEPTH));
  assign w_widx    = c_idx_w'(word_idx(32'(bus.prog_addr_i), DEPTH));

  assign bus.req_ready_o = rst_ni && !bus.flush_i &&
                           (r_state == IDLE || (r_state == RESP && bus.rsp_ready_i));
  assign w_accept        = bus.req_valid_i && bus.req_ready_o;

  imem_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE),
    .NOP_WORD  (NOP_WORD),
    .IDX_W     (c_idx_w)
  ) u_array (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .re     (w_accept),
    .raddr  (w_ridx),
    .we     (bus.prog_we_i && w_prog_ok),
    .waddr  (w_widx),
    .wdata  (bus.prog_data_i),
    .rdata  (w_arr_q)
  );

  assign w_cap_data = r_cap_fault ? NOP_WORD : w_arr_q;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_out  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY > 1) w_state_nxt = WAIT;
          else             w_state_nxt = RESP;
          w_cnt_nxt = c_cnt_load;
        end
      end
      WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = RESP;
          w_load_out  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      RESP: begin
        if (w_accept) begin
          if (LATENCY > 1) w_state_nxt = WAIT;
          else             w_state_nxt = RESP;
          w_cnt_nxt = c_cnt_load;
        end else if (bus.rsp_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Flush outranks both response consumption and the WAIT->RESP step.
    if (bus.flush_i) begin
      w_state_nxt = IDLE;
      w_load_out  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_cap_fault <= 1'b0;
      r_rsp_data  <= NOP_WORD;
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_cap_fault <= w_fault;
        if (w_fault && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      // Second stage so outputs stay put while the fetch sits in WAIT.
      if (w_load_out) begin
        r_rsp_data <= w_cap_data;
        r_rsp_err  <= r_cap_fault;
      end
    end
  end

  // At LATENCY=1 the array read register changes only on accept, which is
  // exactly when a new response appears, so it drives the outputs directly.
  assign bus.rsp_valid_o = (r_state == RESP);
  assign bus.rsp_data_o  = (LATENCY == 1) ? w_cap_data  : r_rsp_data;
  assign bus.rsp_err_o   = (LATENCY == 1) ? r_cap_fault : r_rsp_err;
  assign bus.err_cnt_o   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_i_memory_pl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_i_memory_pl                                                   |
// | Purpose : Directed self-checking bench for i_memory_pl at LATENCY 1, 3, 4  |
// |           sharing one clock and reset.                                     |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial handshaked instruction memory                       |
// +----------------------------------------------------------------------------+
module tb_i_memory_pl;

  localparam logic [31:0] c_nop = 32'h0000_0013;
  localparam logic [31:0] c_w0  = 32'h0050_0093;
  localparam logic [31:0] c_w1  = 32'h0010_2223;
  localparam logic [31:0] c_w2  = 32'h0010_8093;
  localparam logic [31:0] c_w3  = 32'h0020_8113;
  localparam logic [31:0] c_new = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  i_memory_pl_if #(.ADDR_W(32)) bus1 ();
  i_memory_pl_if #(.ADDR_W(32)) bus3 ();
  i_memory_pl_if #(.ADDR_W(32)) bus4 ();

  i_memory_pl #(.ADDR_W(32), .DEPTH(256), .LATENCY(1), .INIT_FILE(""), .NOP_WORD(c_nop))
    u_l1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
  i_memory_pl #(.ADDR_W(32), .DEPTH(256), .LATENCY(3), .INIT_FILE(""), .NOP_WORD(c_nop))
    u_l3 (.clk_i(clk), .rst_ni(rst_n), .bus(bus3));
  i_memory_pl #(.ADDR_W(32), .DEPTH(256), .LATENCY(4), .INIT_FILE(""), .NOP_WORD(c_nop))
    u_l4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4));

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_all(input logic [31:0] addr, input logic [31:0] data);
    bus1.prog_we_i = 1'b1; bus1.prog_addr_i = addr; bus1.prog_data_i = data;
    bus3.prog_we_i = 1'b1; bus3.prog_addr_i = addr; bus3.prog_data_i = data;
    bus4.prog_we_i = 1'b1; bus4.prog_addr_i = addr; bus4.prog_data_i = data;
    tick();
    bus1.prog_we_i = 1'b0; bus3.prog_we_i = 1'b0; bus4.prog_we_i = 1'b0;
  endtask

  logic [31:0] words [4];
  logic [31:0] b2b   [4];

  initial begin
    words[0] = c_w0; words[1] = c_w1; words[2] = c_w2; words[3] = c_w3;
    b2b[0] = c_w0; b2b[1] = c_w1; b2b[2] = c_new; b2b[3] = c_w3;

    bus1.req_valid_i = 0; bus1.req_addr_i = 0; bus1.rsp_ready_i = 0; bus1.flush_i = 0;
    bus1.prog_we_i = 0; bus1.prog_addr_i = 0; bus1.prog_data_i = 0;
    bus3.req_valid_i = 0; bus3.req_addr_i = 0; bus3.rsp_ready_i = 0; bus3.flush_i = 0;
    bus3.prog_we_i = 0; bus3.prog_addr_i = 0; bus3.prog_data_i = 0;
    bus4.req_valid_i = 0; bus4.req_addr_i = 0; bus4.rsp_ready_i = 0; bus4.flush_i = 0;
    bus4.prog_we_i = 0; bus4.prog_addr_i = 0; bus4.prog_data_i = 0;

    // ---- reset values
    repeat (3) tick();
    check_value("rst_ready",   32'(bus1.req_ready_o), 32'd0);
    check_value("rst_valid",   32'(bus1.rsp_valid_o), 32'd0);
    check_value("rst_data",    bus1.rsp_data_o,       c_nop);
    check_value("rst_err",     32'(bus1.rsp_err_o),   32'd0);
    check_value("rst_errcnt",  32'(bus1.err_cnt_o),   32'd0);
    check_value("rst_data_l4", bus4.rsp_data_o,       c_nop);
    rst_n = 1'b1;
    #1;
    check_value("rel_ready", 32'(bus1.req_ready_o), 32'd1);
    tick();
    check_value("rel_valid", 32'(bus1.rsp_valid_o), 32'd0);
    check_value("rel_data",  bus1.rsp_data_o,       c_nop);

    // ---- program load, plus a misaligned and an aliasing out-of-range write
    for (int i = 0; i < 4; i++) prog_all(32'(4 * i), words[i]);
    prog_all(32'h0000_000E, 32'hBAD0_0001);
    prog_all(32'h0000_040C, 32'hBAD0_0002);

    // ---- LATENCY=1 single fetch
    bus1.req_valid_i = 1; bus1.req_addr_i = 32'h0; bus1.rsp_ready_i = 1;
    tick();
    bus1.req_valid_i = 0;
    check_value("l1_valid", 32'(bus1.rsp_valid_o), 32'd1);
    check_value("l1_data",  bus1.rsp_data_o,       c_w0);
    check_value("l1_err",   32'(bus1.rsp_err_o),   32'd0);
    tick();
    check_value("l1_drop",  32'(bus1.rsp_valid_o), 32'd0);
    check_value("l1_hold",  bus1.rsp_data_o,       c_w0);

    // ---- LATENCY=3 timing and backpressure
    bus3.req_valid_i = 1; bus3.req_addr_i = 32'h4; bus3.rsp_ready_i = 0;
    tick();
    bus3.req_valid_i = 0;
    check_value("l3_e0", 32'(bus3.rsp_valid_o), 32'd0);
    tick();
    check_value("l3_e1", 32'(bus3.rsp_valid_o), 32'd0);
    tick();
    check_value("l3_e2",   32'(bus3.rsp_valid_o), 32'd1);
    check_value("l3_data", bus3.rsp_data_o,       c_w1);
    bus3.req_valid_i = 1; bus3.req_addr_i = 32'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_value("l3_bp_ready", 32'(bus3.req_ready_o), 32'd0);
      tick();
      check_value("l3_bp_valid", 32'(bus3.rsp_valid_o), 32'd1);
      check_value("l3_bp_data",  bus3.rsp_data_o,       c_w1);
    end
    bus3.req_valid_i = 0; bus3.rsp_ready_i = 1;
    tick();
    check_value("l3_consumed", 32'(bus3.rsp_valid_o), 32'd0);

    // ---- faults and saturating error counter (LATENCY=1, back-to-back)
    bus1.req_valid_i = 1; bus1.req_addr_i = 32'h6; bus1.rsp_ready_i = 1;
    tick();
    check_value("mis_data", bus1.rsp_data_o,       c_nop);
    check_value("mis_err",  32'(bus1.rsp_err_o),   32'd1);
    check_value("mis_cnt",  32'(bus1.err_cnt_o),   32'd1);
    bus1.req_addr_i = 32'h400;
    tick();
    check_value("oor_data", bus1.rsp_data_o,       c_nop);
    check_value("oor_err",  32'(bus1.rsp_err_o),   32'd1);
    check_value("oor_cnt",  32'(bus1.err_cnt_o),   32'd2);
    bus1.req_addr_i = 32'h6;
    repeat (298) tick();
    check_value("sat_cnt", 32'(bus1.err_cnt_o), 32'd255);
    bus1.req_addr_i = 32'h0;
    tick();
    check_value("ok_err",  32'(bus1.rsp_err_o), 32'd0);
    check_value("ok_data", bus1.rsp_data_o,     c_w0);
    check_value("ok_cnt",  32'(bus1.err_cnt_o), 32'd255);

    // ---- read-first on a same-edge write and fetch
    bus1.req_addr_i = 32'h8;
    bus1.prog_we_i = 1; bus1.prog_addr_i = 32'h8; bus1.prog_data_i = c_new;
    tick();
    bus1.prog_we_i = 0;
    check_value("rf_old", bus1.rsp_data_o, c_w2);
    tick();
    check_value("rf_new", bus1.rsp_data_o, c_new);
    bus1.req_valid_i = 0;
    tick();

    // ---- back-to-back fetches 0,4,8,12
    bus1.req_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      bus1.req_addr_i = 32'(4 * i);
      tick();
      check_value("b2b_valid", 32'(bus1.rsp_valid_o), 32'd1);
      check_value("b2b_data",  bus1.rsp_data_o,       b2b[i]);
      check_value("b2b_err",   32'(bus1.rsp_err_o),   32'd0);
    end
    bus1.req_valid_i = 0;
    tick();
    check_value("b2b_end", 32'(bus1.rsp_valid_o), 32'd0);

    // ---- LATENCY=4 timing
    bus4.req_valid_i = 1; bus4.req_addr_i = 32'hC; bus4.rsp_ready_i = 1;
    tick();
    bus4.req_valid_i = 0;
    check_value("l4_e0", 32'(bus4.rsp_valid_o), 32'd0);
    tick();
    check_value("l4_e1", 32'(bus4.rsp_valid_o), 32'd0);
    tick();
    check_value("l4_e2", 32'(bus4.rsp_valid_o), 32'd0);
    tick();
    check_value("l4_e3",   32'(bus4.rsp_valid_o), 32'd1);
    check_value("l4_data", bus4.rsp_data_o,       c_w3);
    tick();
    check_value("l4_done", 32'(bus4.rsp_valid_o), 32'd0);

    // ---- LATENCY=4 flush two cycles after accept
    bus4.req_valid_i = 1; bus4.req_addr_i = 32'h0;
    tick();
    bus4.req_valid_i = 0;
    tick();
    bus4.flush_i = 1;
    #1;
    check_value("fl_ready_lo", 32'(bus4.req_ready_o), 32'd0);
    tick();
    bus4.flush_i = 0;
    #1;
    check_value("fl_ready_hi", 32'(bus4.req_ready_o), 32'd1);
    check_value("fl_valid0",   32'(bus4.rsp_valid_o), 32'd0);
    tick();
    check_value("fl_valid1",   32'(bus4.rsp_valid_o), 32'd0);
    tick();
    check_value("fl_valid2",   32'(bus4.rsp_valid_o), 32'd0);
    check_value("fl_hold",     bus4.rsp_data_o,       c_w3);

    // ---- LATENCY=4 reset mid-WAIT on a faulting fetch
    bus4.req_valid_i = 1; bus4.req_addr_i = 32'h6;
    tick();
    bus4.req_valid_i = 0;
    check_value("rw_cnt1", 32'(bus4.err_cnt_o), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check_value("rw_ready",  32'(bus4.req_ready_o), 32'd1);
    check_value("rw_valid0", 32'(bus4.rsp_valid_o), 32'd0);
    check_value("rw_cnt0",   32'(bus4.err_cnt_o),   32'd0);
    check_value("rw_data",   bus4.rsp_data_o,       c_nop);
    tick();
    check_value("rw_valid1", 32'(bus4.rsp_valid_o), 32'd0);
    tick();
    check_value("rw_valid2", 32'(bus4.rsp_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
